decode_stage: RTL and testbench

//  Registered RV32I decode pipeline stage between fetch and register-read/execute.
//  - Accepts {instr, pc} over a valid/ready handshake.
//  - Splits the instruction into its fields, classifies the format, generates the

---
 rtl/rv_pkg.sv | 24 ++
 rtl/decode_stage_if.sv | 37 +++
 rtl/rv_imm_gen.sv | 51 +++++
 rtl/decode_stage.sv | 100 ++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// RV32I base opcodes and decoded-format encodings shared by the decode path.
package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side valid/ready buses of the decode stage.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    // Decode stage view
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal
    );

    // Surrounding pipeline view
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational RV32I format classifier and immediate generator.
// Shared with the compressed-expansion path, so it stays free of state.
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;

    // Classify by the full 7-bit opcode; every legal one ends in 2'b11,
    // so compressed or non-32-bit words fall through to BAD as well.
    always_comb begin
        fmt = FMT_BAD;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                  fmt = FMT_U;
            OPC_JAL:                             fmt = FMT_J;
            OPC_BRANCH:                          fmt = FMT_B;
            OPC_STORE:                           fmt = FMT_S;
            OPC_OP:                              fmt = FMT_R;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:            fmt = FMT_I;
            default:                             fmt = FMT_BAD;
        endcase
        illegal = (fmt == FMT_BAD);
    end

    // Assemble the 32-bit sign-extended immediate for the detected format
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widen to XLEN keeping the sign
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register backed by one skid entry,
// so in_ready can come straight from a flop without losing throughput.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    decode_stage_if.slave bus
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t          in_entry;
    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [2:0]      in_fmt;
    logic [XLEN-1:0] in_imm;
    logic            in_illegal;
    logic            accept;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (bus.in_instr),
        .fmt     (in_fmt),
        .imm     (in_imm),
        .illegal (in_illegal)
    );

    assign in_entry = '{pc: bus.in_pc, instr: bus.in_instr, fmt: in_fmt,
                        imm: in_imm, illegal: in_illegal};

    // Flush blocks acceptance in the same cycle it is raised
    assign accept = bus.in_valid & ~skid_valid_q & ~flush;

    // Next-state for the output register and skid entry
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Output slot frees up: the older skid entry goes first
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the word accepted under a still-high in_ready
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_opcode  = out_q.instr[6:0];
    assign bus.out_rd      = out_q.instr[11:7];
    assign bus.out_funct3  = out_q.instr[14:12];
    assign bus.out_rs1     = out_q.instr[19:15];
    assign bus.out_rs2     = out_q.instr[24:20];
    assign bus.out_funct7  = out_q.instr[31:25];
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush, reset.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

    decode_stage #(.XLEN(32), .PC_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        bus.in_valid = v;
        bus.in_instr = i;
        bus.in_pc    = p;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vec_t;

    vec_t vecs [8];
    logic exp_rdy [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx;
        int rx;
        logic acc;
        logic fire;
        logic [31:0] op;

        //               instr         fmt   imm           ill   rd     rs1    rs2    f3    f7
        vecs[0] = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd1,  5'd2, 5'd31, 3'd0, 7'h7F};
        vecs[1] = '{32'h00112623, 3'd2, 32'h0000000C, 1'b0, 5'd12, 5'd2, 5'd1,  3'd2, 7'h00};
        vecs[2] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F};
        vecs[3] = '{32'h12345137, 3'd4, 32'h12345000, 1'b0, 5'd2,  5'd8, 5'd3,  3'd5, 7'h09};
        vecs[4] = '{32'h008000EF, 3'd5, 32'h00000008, 1'b0, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00};
        vecs[5] = '{32'h402081B3, 3'd0, 32'h00000000, 1'b0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h20};
        vecs[6] = '{32'h00000000, 3'd7, 32'h00000000, 1'b1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00};
        vecs[7] = '{32'h0000007F, 3'd7, 32'h00000000, 1'b1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00};

        // in_ready before each edge of the backpressure run (skid full cycles 3-6)
        for (int c = 0; c < 14; c++) exp_rdy[c] = !(c >= 3 && c <= 6);

        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;

        // reset
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_pc",    64'(bus.out_pc),    64'd0);
        check("rst_out_imm",   64'(bus.out_imm),   64'd0);
        check("rst_out_fmt",   64'(bus.out_fmt),   64'd0);
        check("rst_illegal",   64'(bus.out_illegal), 64'd0);

        // back-to-back decode stream, one bundle expected every cycle
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, vecs[k].instr, 32'h100 + 32'(k * 4));
            tick();
            op = vecs[k].instr;
            check("dec_valid",   64'(bus.out_valid),   64'd1);
            check("dec_pc",      64'(bus.out_pc),      64'(32'h100 + 32'(k * 4)));
            check("dec_opcode",  64'(bus.out_opcode),  64'(op[6:0]));
            check("dec_fmt",     64'(bus.out_fmt),     64'(vecs[k].fmt));
            check("dec_imm",     64'(bus.out_imm),     64'(vecs[k].imm));
            check("dec_illegal", 64'(bus.out_illegal), 64'(vecs[k].ill));
            check("dec_rd",      64'(bus.out_rd),      64'(vecs[k].rd));
            check("dec_rs1",     64'(bus.out_rs1),     64'(vecs[k].rs1));
            check("dec_rs2",     64'(bus.out_rs2),     64'(vecs[k].rs2));
            check("dec_funct3",  64'(bus.out_funct3),  64'(vecs[k].f3));
            check("dec_funct7",  64'(bus.out_funct7),  64'(vecs[k].f7));
            check("dec_in_ready", 64'(bus.in_ready),   64'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_drain", 64'(bus.out_valid), 64'd0);

        // backpressure: six words, out_ready low in cycles 2-5
        tx = 0;
        rx = 0;
        for (int c = 0; c < 14; c++) begin
            bus.out_ready = !(c >= 2 && c <= 5);
            drive(tx < 6, 32'h00000013, 32'(tx * 4));
            check("bp_in_ready", 64'(bus.in_ready), 64'(exp_rdy[c]));
            if (c >= 3 && c <= 5) check("bp_hold_pc", 64'(bus.out_pc), 64'h4);
            acc  = bus.in_valid && bus.in_ready;
            fire = bus.out_valid && bus.out_ready;
            if (fire) begin
                check("bp_order_pc", 64'(bus.out_pc), 64'(rx * 4));
                rx++;
            end
            tick();
            if (acc) tx++;
        end
        check("bp_rx_count", 64'(rx), 64'd6);
        check("bp_tx_count", 64'(tx), 64'd6);
        drive(1'b0, 32'h0, 32'h0);

        // flush with output and skid both full and a word on the input
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h200);
        tick();
        drive(1'b1, 32'h00100093, 32'h204);
        tick();
        check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        check("fl_pre_ready", 64'(bus.in_ready),  64'd0);
        check("fl_pre_pc",    64'(bus.out_pc),    64'h200);
        drive(1'b1, 32'h00200113, 32'h208);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_in_ready",  64'(bus.in_ready),  64'd1);
        tick();
        check("fl_no_skid_emit", 64'(bus.out_valid), 64'd0);

        // flush suppresses acceptance while in_ready is high
        drive(1'b1, 32'h00300193, 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_suppress", 64'(bus.out_valid), 64'd0);
        drive(1'b1, 32'h00300193, 32'h304);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("fl_recover_valid", 64'(bus.out_valid), 64'd1);
        check("fl_recover_pc",    64'(bus.out_pc),    64'h304);
        tick();

        // asynchronous reset mid-stream with output and skid full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF10093, 32'h400);
        tick();
        drive(1'b1, 32'h00112623, 32'h404);
        tick();
        check("rs_pre_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", 64'(bus.out_valid), 64'd0);
        check("rs_async_pc",    64'(bus.out_pc),    64'd0);
        check("rs_async_imm",   64'(bus.out_imm),   64'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("rs_post_valid", 64'(bus.out_valid), 64'd0);
        check("rs_post_ready", 64'(bus.in_ready),  64'd1);
        tick();
        check("rs_no_survivor", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
